// File: rtl/gcm_aes_out_collector.sv
// Receive-side collector for the gcm_aes_v0 result stream: FIFOs the payload words,
// captures and compares the tag, and reports completion, overflow and protocol errors.
module gcm_aes_out_collector #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             start,
    input  logic [127:0]     Out_data,
    input  logic             Out_vld,
    input  logic [3:0]       Out_data_size,
    input  logic             Out_last_word,
    input  logic             Tag_vld,
    input  logic [127:0]     exp_tag,
    input  logic             rd_en,
    output logic [127:0]     rd_data,
    output logic [3:0]       rd_size,
    output logic             rd_last,
    output logic             fifo_empty,
    output logic [AW:0]      fifo_count,
    output logic [CNT_W-1:0] word_cnt,
    output logic [127:0]     tag_out,
    output logic             tag_match,
    output logic             msg_done,
    output logic             overflow,
    output logic             err_unexp
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_COLLECT  = 2'd1;
    localparam logic [1:0] ST_TAG_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE     = 2'd3;

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [1:0]    state, state_nxt;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;

    logic [127:0]  mem_data [DEPTH];
    logic [3:0]    mem_size [DEPTH];
    logic          mem_last [DEPTH];

    logic armed, is_empty, is_full;
    logic wr_req, tag_hit, pop, push, drop, unexp;

    // Keeps the top (size+1) bytes; size 4'hF leaves the word untouched.
    function automatic logic [127:0] byte_mask(input logic [3:0] size);
        logic [6:0] shamt;
        shamt = {4'd15 - size, 3'b000};
        return {128{1'b1}} << shamt;
    endfunction

    assign armed    = (state == ST_COLLECT) || (state == ST_TAG_WAIT);
    assign is_empty = (count == '0);
    assign is_full  = (count == FULL_CNT);

    // start has priority over every strobe in the same cycle, and Tag_vld over Out_vld.
    assign tag_hit = !start && Tag_vld && armed;
    assign wr_req  = !start && Out_vld && !Tag_vld && (state == ST_COLLECT);
    assign pop     = rd_en && !is_empty;
    assign push    = wr_req && (!is_full || pop);
    assign drop    = wr_req && is_full && !pop;
    assign unexp   = !start &&
                     ((((state == ST_IDLE) || (state == ST_DONE)) && (Out_vld || Tag_vld)) ||
                      ((state == ST_TAG_WAIT) && Out_vld && !Tag_vld));

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = ST_COLLECT;
        end else begin
            case (state)
                ST_COLLECT: begin
                    if (Tag_vld)
                        state_nxt = ST_DONE;
                    else if (Out_vld && Out_last_word)
                        state_nxt = ST_TAG_WAIT;
                end
                ST_TAG_WAIT: begin
                    if (Tag_vld)
                        state_nxt = ST_DONE;
                end
                default: state_nxt = state;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (start) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    // NOTE: the storage array has no reset; the read port forces zeros while the FIFO is empty,
    // so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= Out_data & byte_mask(Out_data_size);
            mem_size[wr_ptr] <= Out_data_size;
            mem_last[wr_ptr] <= Out_last_word;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            word_cnt  <= '0;
            tag_out   <= '0;
            tag_match <= 1'b0;
            msg_done  <= 1'b0;
            overflow  <= 1'b0;
            err_unexp <= 1'b0;
        end else if (start) begin
            word_cnt  <= '0;
            tag_out   <= '0;
            tag_match <= 1'b0;
            msg_done  <= 1'b0;
            overflow  <= 1'b0;
            err_unexp <= 1'b0;
        end else begin
            // Dropped words still count: word_cnt tracks what the core emitted.
            if (wr_req && (word_cnt != '1))
                word_cnt <= word_cnt + 1'b1;
            if (tag_hit) begin
                tag_out   <= Out_data;
                tag_match <= (Out_data == exp_tag);
                msg_done  <= 1'b1;
            end
            if (drop)
                overflow <= 1'b1;
            if (unexp)
                err_unexp <= 1'b1;
        end
    end

    assign fifo_empty = is_empty;
    assign fifo_count = count;
    assign rd_data    = is_empty ? '0 : mem_data[rd_ptr];
    assign rd_size    = is_empty ? '0 : mem_size[rd_ptr];
    assign rd_last    = is_empty ? 1'b0 : mem_last[rd_ptr];

endmodule

// File: tb/tb_gcm_aes_out_collector.sv
// Directed bench for gcm_aes_out_collector using GCM test vectors TC3/TC4 and FIFO corner cases.
module tb_gcm_aes_out_collector;

    logic         clk = 1'b0;
    logic         clrn;
    logic         start;
    logic [127:0] Out_data;
    logic         Out_vld;
    logic [3:0]   Out_data_size;
    logic         Out_last_word;
    logic         Tag_vld;
    logic [127:0] exp_tag;
    logic         rd_en;
    logic [127:0] rd_data;
    logic [3:0]   rd_size;
    logic         rd_last;
    logic         fifo_empty;
    logic [3:0]   fifo_count;
    logic [15:0]  word_cnt;
    logic [127:0] tag_out;
    logic         tag_match;
    logic         msg_done;
    logic         overflow;
    logic         err_unexp;

    int n_checks = 0;
    int n_errors = 0;

    logic [127:0] ct [4] = '{
        128'h42831ec2217774244b7221b784d0d49c,
        128'he3aa212f2c02a4e035c17e2329aca12e,
        128'h21d514b25466931c7d8f6a5aac84aa05,
        128'h1ba30b396a0aac973d58e091473f5985
    };
    logic [127:0] tag_tc3 = 128'h4d5c2af327cd64a62cf35abd2ba6fab4;
    logic [127:0] tag_tc4 = 128'h5bc94fbc3221a5db94fae95ae7121a47;
    logic [127:0] tc4_last = 128'h1ba30b396a0aac973d58e09100000000;

    gcm_aes_out_collector #(.DEPTH(8), .AW(3), .CNT_W(16)) dut (
        .clk(clk), .clrn(clrn), .start(start),
        .Out_data(Out_data), .Out_vld(Out_vld), .Out_data_size(Out_data_size),
        .Out_last_word(Out_last_word), .Tag_vld(Tag_vld), .exp_tag(exp_tag),
        .rd_en(rd_en), .rd_data(rd_data), .rd_size(rd_size), .rd_last(rd_last),
        .fifo_empty(fifo_empty), .fifo_count(fifo_count), .word_cnt(word_cnt),
        .tag_out(tag_out), .tag_match(tag_match), .msg_done(msg_done),
        .overflow(overflow), .err_unexp(err_unexp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_word(input logic [127:0] d, input logic [3:0] s, input logic last,
                             input logic rd);
        Out_data      = d;
        Out_data_size = s;
        Out_last_word = last;
        Out_vld       = 1'b1;
        rd_en         = rd;
        tick();
        Out_vld       = 1'b0;
        Out_last_word = 1'b0;
        rd_en         = 1'b0;
    endtask

    task automatic send_tag(input logic [127:0] t);
        Out_data = t;
        Tag_vld  = 1'b1;
        tick();
        Tag_vld  = 1'b0;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        clrn = 1'b0; start = 1'b0; Out_data = '0; Out_vld = 1'b0; Out_data_size = 4'h0;
        Out_last_word = 1'b0; Tag_vld = 1'b0; exp_tag = '0; rd_en = 1'b0;
        repeat (2) tick();
        check("rst_empty", fifo_empty, 1);
        check("rst_rd_data", rd_data, 0);
        check("rst_msg_done", msg_done, 0);
        clrn = 1'b1;
        tick();

        // 1: reset mid-COLLECT with three words queued
        do_start();
        for (int i = 0; i < 3; i++) send_word(ct[i], 4'hF, 1'b0, 1'b0);
        check("t1_count_pre", fifo_count, 3);
        check("t1_wcnt_pre", word_cnt, 3);
        #2 clrn = 1'b0;
        #1;
        check("t1_rd_data", rd_data, 0);
        check("t1_rd_size", rd_size, 0);
        check("t1_rd_last", rd_last, 0);
        check("t1_empty", fifo_empty, 1);
        check("t1_count", fifo_count, 0);
        check("t1_wcnt", word_cnt, 0);
        check("t1_tag_out", tag_out, 0);
        check("t1_flags", {tag_match, msg_done, overflow, err_unexp}, 0);
        tick();
        clrn = 1'b1;
        tick();
        send_word(ct[0], 4'hF, 1'b0, 1'b0);
        check("t1_idle_err", err_unexp, 1);
        check("t1_idle_nowr", fifo_count, 0);

        // 2: GCM TC3, four full words then the tag
        do_start();
        check("t2_err_clr", err_unexp, 0);
        for (int i = 0; i < 4; i++) send_word(ct[i], 4'hF, i == 3, 1'b0);
        check("t2_wcnt", word_cnt, 4);
        check("t2_count", fifo_count, 4);
        check("t2_head", rd_data, ct[0]);
        check("t2_head_size", rd_size, 4'hF);
        check("t2_head_last", rd_last, 0);
        check("t2_not_done", msg_done, 0);
        exp_tag = tag_tc3;
        send_tag(tag_tc3);
        check("t2_tag_out", tag_out, tag_tc3);
        check("t2_tag_match", tag_match, 1);
        check("t2_msg_done", msg_done, 1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_rd%0d", i), rd_data, ct[i]);
            check($sformatf("t2_last%0d", i), rd_last, i == 3);
            pop();
        end
        check("t2_drained", fifo_empty, 1);

        // 3: GCM TC4, 60-byte payload, last word carries 12 bytes
        do_start();
        for (int i = 0; i < 4; i++) send_word(ct[i], (i == 3) ? 4'hB : 4'hF, i == 3, 1'b0);
        for (int i = 0; i < 3; i++) pop();
        check("t3_last_data", rd_data, tc4_last);
        check("t3_last_size", rd_size, 4'hB);
        check("t3_last_flag", rd_last, 1);
        exp_tag = tag_tc4 ^ 128'h1;
        send_tag(tag_tc4);
        check("t3_tag_out", tag_out, tag_tc4);
        check("t3_tag_match", tag_match, 0);
        check("t3_msg_done", msg_done, 1);

        // 4: overflow on the ninth word, then the same with a simultaneous read
        do_start();
        for (int i = 1; i <= 8; i++) send_word(128'(i), 4'hF, 1'b0, 1'b0);
        check("t4_full_count", fifo_count, 8);
        check("t4_no_ovf_yet", overflow, 0);
        send_word(128'(9), 4'hF, 1'b0, 1'b0);
        check("t4_overflow", overflow, 1);
        check("t4_count", fifo_count, 8);
        check("t4_wcnt", word_cnt, 9);
        check("t4_head", rd_data, 1);
        do_start();
        for (int i = 1; i <= 8; i++) send_word(128'(i), 4'hF, 1'b0, 1'b0);
        send_word(128'(9), 4'hF, 1'b0, 1'b1);
        check("t4b_overflow", overflow, 0);
        check("t4b_count", fifo_count, 8);
        check("t4b_wcnt", word_cnt, 9);
        for (int k = 2; k <= 9; k++) begin
            check($sformatf("t4b_rd%0d", k), rd_data, 128'(k));
            pop();
        end
        check("t4b_empty", fifo_empty, 1);

        // 5: AAD-only message, then a stray data strobe
        do_start();
        exp_tag = tag_tc3;
        send_tag(tag_tc3);
        check("t5_done", msg_done, 1);
        check("t5_match", tag_match, 1);
        check("t5_empty", fifo_empty, 1);
        check("t5_wcnt", word_cnt, 0);
        check("t5_no_err", err_unexp, 0);
        send_word(ct[1], 4'hF, 1'b0, 1'b0);
        check("t5_err", err_unexp, 1);
        check("t5_nowr", fifo_count, 0);

        // 6: restart from TAG_WAIT, read on empty, start beating a same-cycle strobe
        do_start();
        send_word(ct[0], 4'hF, 1'b0, 1'b0);
        send_word(ct[1], 4'h7, 1'b1, 1'b0);
        send_word(ct[2], 4'hF, 1'b0, 1'b0);
        check("t6_tw_err", err_unexp, 1);
        check("t6_tw_count", fifo_count, 2);
        do_start();
        check("t6_cleared", fifo_empty, 1);
        check("t6_err_clr", err_unexp, 0);
        pop();
        check("t6_pop_empty", fifo_count, 0);
        check("t6_pop_data", rd_data, 0);
        send_word(ct[3], 4'h0, 1'b0, 1'b0);
        check("t6_collect", fifo_count, 1);
        check("t6_mask0", rd_data, 128'h1b000000000000000000000000000000);
        check("t6_no_err", err_unexp, 0);
        start = 1'b1;
        send_word(ct[0], 4'hF, 1'b0, 1'b0);
        start = 1'b0;
        check("t6_start_win", fifo_count, 0);
        check("t6_start_noerr", err_unexp, 0);
        check("t6_start_wcnt", word_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
